// File: rtl/audio_avg_filter_pkg.sv
// Shared defaults, channel count and FSM encoding for the audio moving-average filter.
package audio_avg_filter_pkg;
  localparam int DATA_W_DEF = 24;
  localparam int LOG2_N_DEF = 3;
  localparam int SUM_W_DEF  = DATA_W_DEF + LOG2_N_DEF;
  localparam int NUM_CH     = 2;  // 0 = left, 1 = right

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    UPDATE,
    WAIT_WR,
    WRITE
  } state_t;
endpackage

// File: rtl/audio_avg_filter_if.sv
// Codec-side stream handshake: ADC pop on the read side, DAC push on the write side.
interface audio_avg_filter_if
  import audio_avg_filter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              read_ready;
  logic              write_ready;
  logic [DATA_W-1:0] readdata_left;
  logic [DATA_W-1:0] readdata_right;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata_left;
  logic [DATA_W-1:0] writedata_right;

  modport master (
    input  read_ready, write_ready, readdata_left, readdata_right,
    output read, write, writedata_left, writedata_right
  );

  modport slave (
    output read_ready, write_ready, readdata_left, readdata_right,
    input  read, write, writedata_left, writedata_right
  );
endinterface

// File: rtl/audio_avg_filter_avg_channel.sv
// One channel of the boxcar filter: delay line, running sum and output register.
module avg_channel
  import audio_avg_filter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LOG2_N = LOG2_N_DEF
) (
  input  logic                     gclk,
  input  logic                     grst_n,
  input  logic                     upd,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [DATA_W-1:0] load_val,
  output logic signed [DATA_W-1:0] avg_nxt,
  output logic signed [DATA_W-1:0] dout
);
  localparam int N     = 1 << LOG2_N;
  localparam int SUM_W = DATA_W + LOG2_N;

  logic [N-1:0][DATA_W-1:0] dly;
  logic signed [SUM_W-1:0]  sum, sum_nxt;

  // Sum is LOG2_N bits wider than a sample, so N full-scale samples never wrap.
  assign sum_nxt = sum + SUM_W'(sample) - SUM_W'($signed(dly[N-1]));
  assign avg_nxt = DATA_W'(sum_nxt >>> LOG2_N);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      dly  <= '0;
      sum  <= '0;
      dout <= '0;
    end else if (upd) begin
      dly  <= {dly[N-2:0], sample};
      sum  <= sum_nxt;
      dout <= load_val;
    end
  end
endmodule

// File: rtl/audio_avg_filter.sv
// Codec pass-through stage: pop a stereo pair, boxcar-average each channel, push it back.
module audio_avg_filter
  import audio_avg_filter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LOG2_N = LOG2_N_DEF
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                enable,
  audio_avg_filter_if.master  codec
);
  state_t state, state_nxt;

  logic [NUM_CH-1:0][DATA_W-1:0] rd, cap, avg, ld, wd;

  assign rd[0] = codec.readdata_left;
  assign rd[1] = codec.readdata_right;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cap   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CAPTURE) cap <= rd;
    end
  end

  always_comb begin
    state_nxt   = state;
    codec.read  = 1'b0;
    codec.write = 1'b0;
    case (state)
      IDLE:    if (codec.read_ready) state_nxt = CAPTURE;
      CAPTURE: begin
        codec.read = 1'b1;
        state_nxt  = UPDATE;
      end
      UPDATE:  state_nxt = WAIT_WR;
      WAIT_WR: if (codec.write_ready) state_nxt = WRITE;
      WRITE:   begin
        codec.write = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    // Bypass only picks what the output register loads; history keeps running.
    assign ld[ch] = enable ? avg[ch] : cap[ch];

    avg_channel #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_ch (
      .gclk     (CLOCK_50),
      .grst_n   (resetn),
      .upd      (state == UPDATE),
      .sample   (cap[ch]),
      .load_val (ld[ch]),
      .avg_nxt  (avg[ch]),
      .dout     (wd[ch])
    );
  end

  assign codec.writedata_left  = wd[0];
  assign codec.writedata_right = wd[1];
endmodule

// File: tb/tb_audio_avg_filter.sv
// Directed bench for audio_avg_filter: step, rounding, full scale, bypass, stall, reset.
module tb_audio_avg_filter;
  localparam int DW = 24;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  logic enable   = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  audio_avg_filter_if #(.DATA_W(DW)) codec_if ();

  audio_avg_filter #(.DATA_W(DW), .LOG2_N(3)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .enable   (enable),
    .codec    (codec_if)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic do_reset();
    @(negedge CLOCK_50);
    resetn                  = 1'b0;
    codec_if.read_ready     = 1'b0;
    codec_if.write_ready    = 1'b1;
    codec_if.readdata_left  = '0;
    codec_if.readdata_right = '0;
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
  endtask

  // One full pop/push transaction; lat = cycles from read to write, -1 on timeout.
  task automatic xfer(input logic [DW-1:0] l, input logic [DW-1:0] r,
                      output logic [DW-1:0] wl, output logic [DW-1:0] wr,
                      output int lat);
    int n;
    lat = -1;
    wl  = 'x;
    wr  = 'x;
    @(negedge CLOCK_50);
    codec_if.readdata_left  = l;
    codec_if.readdata_right = r;
    codec_if.read_ready     = 1'b1;
    n = 0;
    while (codec_if.read !== 1'b1 && n < 50) begin
      @(negedge CLOCK_50);
      n++;
    end
    codec_if.read_ready = 1'b0;
    if (n >= 50) return;
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (codec_if.write !== 1'b1 && n < 50);
    if (codec_if.write === 1'b1) begin
      lat = n;
      wl  = codec_if.writedata_left;
      wr  = codec_if.writedata_right;
    end
  endtask

  task automatic test_reset();
    do_reset();
    resetn = 1'b0;
    @(negedge CLOCK_50);
    tests_run++;
    if (codec_if.read !== 1'b0 || codec_if.write !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_strobes: read=%b write=%b expected 0 0", codec_if.read, codec_if.write);
    end
    tests_run++;
    if (codec_if.writedata_left !== '0 || codec_if.writedata_right !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: l=%h r=%h expected 0 0",
               codec_if.writedata_left, codec_if.writedata_right);
    end
    resetn = 1'b1;
  endtask

  task automatic test_step();
    logic [DW-1:0] wl, wr, exp;
    int lat;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      xfer(24'd800, 24'd0, wl, wr, lat);
      exp = DW'(((i < 8) ? i + 1 : 8) * 100);
      tests_run++;
      if (wl !== exp || wr !== '0) begin
        tests_failed++;
        $display("FAIL step[%0d]: l=%0d r=%0d expected %0d 0", i, wl, wr, exp);
      end
      tests_run++;
      if (lat !== 3) begin
        tests_failed++;
        $display("FAIL step_latency[%0d]: %0d cycles expected 3", i, lat);
      end
    end
  endtask

  task automatic test_negative();
    logic [DW-1:0] wl, wr, exp;
    int lat;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      xfer(-24'sd8, 24'd0, wl, wr, lat);
      exp = DW'(-(i + 1));
      tests_run++;
      if (wl !== exp) begin
        tests_failed++;
        $display("FAIL neg[%0d]: l=%0d expected %0d", i, $signed(wl), $signed(exp));
      end
    end
    do_reset();
    xfer(-24'sd1, 24'd0, wl, wr, lat);
    tests_run++;
    if (wl !== 24'hFFFFFF) begin
      tests_failed++;
      $display("FAIL floor_minus1: l=%h expected ffffff", wl);
    end
  endtask

  task automatic test_full_scale();
    logic [DW-1:0] wl, wr;
    int lat;
    do_reset();
    for (int i = 0; i < 10; i++) xfer(24'h7FFFFF, 24'h7FFFFF, wl, wr, lat);
    tests_run++;
    if (wl !== 24'h7FFFFF || wr !== 24'h7FFFFF) begin
      tests_failed++;
      $display("FAIL full_pos: l=%h r=%h expected 7fffff 7fffff", wl, wr);
    end
    for (int i = 0; i < 8; i++) xfer(24'h800000, 24'h800000, wl, wr, lat);
    tests_run++;
    if (wl !== 24'h800000 || wr !== 24'h800000) begin
      tests_failed++;
      $display("FAIL full_neg: l=%h r=%h expected 800000 800000", wl, wr);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] wl, wr;
    logic [DW-1:0] vin [3];
    int lat;
    vin[0] = 24'd5;
    vin[1] = -24'sd3;
    vin[2] = 24'd7;
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      xfer(vin[i], vin[i], wl, wr, lat);
      tests_run++;
      if (wl !== vin[i] || wr !== vin[i]) begin
        tests_failed++;
        $display("FAIL bypass[%0d]: l=%h r=%h expected %h", i, wl, wr, vin[i]);
      end
    end
    enable = 1'b1;
    xfer(24'd1, 24'd1, wl, wr, lat);
    tests_run++;
    if (wl !== 24'd1 || wr !== 24'd1) begin
      tests_failed++;
      $display("FAIL bypass_reenable: l=%h r=%h expected 1 1", wl, wr);
    end
  endtask

  task automatic test_back_pressure();
    int n, bad, nw;
    do_reset();
    enable = 1'b1;
    codec_if.write_ready = 1'b0;
    @(negedge CLOCK_50);
    codec_if.readdata_left  = 24'd800;
    codec_if.readdata_right = 24'd0;
    codec_if.read_ready     = 1'b1;  // stays high: must be ignored while busy
    n = 0;
    while (codec_if.read !== 1'b1 && n < 50) begin
      @(negedge CLOCK_50);
      n++;
    end
    @(negedge CLOCK_50);
    bad = 0;
    repeat (20) begin
      @(negedge CLOCK_50);
      if (codec_if.read !== 1'b0 || codec_if.write !== 1'b0 ||
          codec_if.writedata_left !== 24'd100 || codec_if.writedata_right !== '0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL stall_hold: %0d bad cycles expected 0", bad);
    end
    codec_if.write_ready = 1'b1;
    codec_if.read_ready  = 1'b0;
    @(negedge CLOCK_50);
    tests_run++;
    if (codec_if.write !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_release: write=%b expected 1", codec_if.write);
    end
    nw = (codec_if.write === 1'b1) ? 1 : 0;
    repeat (5) begin
      @(negedge CLOCK_50);
      if (codec_if.write === 1'b1) nw++;
    end
    tests_run++;
    if (nw != 1) begin
      tests_failed++;
      $display("FAIL stall_single_write: %0d writes expected 1", nw);
    end
  endtask

  task automatic test_reset_midflight();
    logic [DW-1:0] wl, wr;
    int n, lat, nw;
    do_reset();
    codec_if.write_ready = 1'b0;
    @(negedge CLOCK_50);
    codec_if.readdata_left  = 24'd800;
    codec_if.readdata_right = 24'd0;
    codec_if.read_ready     = 1'b1;
    n = 0;
    while (codec_if.read !== 1'b1 && n < 50) begin
      @(negedge CLOCK_50);
      n++;
    end
    codec_if.read_ready = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b0;
    #1;
    tests_run++;
    if (codec_if.writedata_left !== '0 || codec_if.write !== 1'b0) begin
      tests_failed++;
      $display("FAIL midflight_clear: l=%h write=%b expected 0 0",
               codec_if.writedata_left, codec_if.write);
    end
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    codec_if.write_ready = 1'b1;
    nw = 0;
    repeat (8) begin
      @(negedge CLOCK_50);
      if (codec_if.write === 1'b1 || codec_if.read === 1'b1) nw++;
    end
    tests_run++;
    if (nw != 0) begin
      tests_failed++;
      $display("FAIL midflight_no_strobe: %0d strobes expected 0", nw);
    end
    xfer(24'd800, 24'd0, wl, wr, lat);
    tests_run++;
    if (wl !== 24'd100 || lat !== 3) begin
      tests_failed++;
      $display("FAIL midflight_history: l=%0d lat=%0d expected 100 3", wl, lat);
    end
  endtask

  initial begin
    codec_if.read_ready     = 1'b0;
    codec_if.write_ready    = 1'b1;
    codec_if.readdata_left  = '0;
    codec_if.readdata_right = '0;
    test_reset();
    test_step();
    test_negative();
    test_full_scale();
    test_bypass();
    test_back_pressure();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/audio_avg_filter.md
Name: audio_avg_filter

Overview:
- Streaming noise-reduction stage between the audio codec's ADC read side and DAC write side, in the user-circuit slot of the top level.
- Pops one stereo sample pair from the codec, applies an N-tap moving-average (boxcar) filter independently per channel, and pushes the filtered pair back to the codec.
- Optional bypass passes raw samples through with identical handshake timing.

Parameters:
DATA_W, 24, signed sample width per channel (two's complement)
LOG2_N, 3, log2 of filter length; N = 2**LOG2_N taps (N=8 default)

Ports:
CLOCK_50  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
enable  input  1  1 = filtered output, 0 = bypass (raw sample)
read_ready  input  1  codec has a sample pair available
write_ready  input  1  codec can accept a sample pair
readdata_left  input  DATA_W  left ADC sample, valid while read_ready=1
readdata_right  input  DATA_W  right ADC sample, valid while read_ready=1
read  output  1  one-cycle pop strobe to codec
write  output  1  one-cycle push strobe to codec
writedata_left  output  DATA_W  left output sample
writedata_right  output  DATA_W  right output sample

Behaviour:
- Reset (resetn=0, async): state=IDLE; read=0, write=0; writedata_*=0; all delay-line entries, running sums and captured samples cleared to 0. Reset mid-operation abandons the sample in flight; no read or write is issued until resetn=1 and read_ready is seen again.
- FSM (Moore outputs): IDLE -> CAPTURE when read_ready=1, else stay.
- CAPTURE: read=1 for exactly this cycle; readdata_* registered at this edge. Next state UPDATE.
- UPDATE: per channel, sum <= sum + new - oldest; the delay line shifts in new and drops oldest; the output register loads. Next state WAIT_WR.
- WAIT_WR: hold. Go to WRITE when write_ready=1.
- WRITE: write=1 for exactly this cycle. Next state IDLE.
- read and write are never both high. At most one sample pair is in flight; read_ready is ignored outside IDLE.
- Minimum latency: read high in cycle k, write high in cycle k+3 (write_ready already high). Write back-pressure stalls in WAIT_WR indefinitely with no read issued. Codec overruns are the codec's concern.
- Arithmetic: sum is signed, width DATA_W+LOG2_N, so it never overflows.
- Filtered output = sum >>> LOG2_N (arithmetic shift, rounds toward -inf), truncated to DATA_W. The result always fits because the mean lies within the input range.
- Start-up: the delay line is zero-filled after reset, so output ramps over the first N samples.
- Bypass: with enable=0, the output register loads the captured raw sample. The delay line and sum still update, so toggling enable gives no transient beyond the filter's own history. enable is sampled in UPDATE only.
- writedata_* are stable from UPDATE until the next UPDATE, i.e. held through WRITE and after it.

Decomposition:
- Shared package holds DATA_W and LOG2_N defaults, the FSM state encoding (IDLE, CAPTURE, UPDATE, WAIT_WR, WRITE), and the derived SUM_W = DATA_W+LOG2_N.
- One sub-module, avg_channel: delay line, running sum and output register for one channel, with a load/update strobe from the FSM. It is instantiated twice (left, right).
- The top holds the FSM and the bypass mux.

Test Plan:
1. Step: 10 pairs of constant left=800, right=0 with write_ready=1 -> left outputs 100,200,...,800, then 800,800; right stays 0. write occurs 3 cycles after each read.
2. Negative/rounding: left=-8 constant -> -1,-2,...,-8. Single left=-1 after reset -> output -1 (floor).
3. Full scale: left=0x7FFFFF x10 -> last output 0x7FFFFF with no wrap. Then 0x800000 x8 -> final 0x800000.
4. Bypass: enable=0, inputs 5,-3,7 -> outputs 5,-3,7 exactly. Switch to enable=1 on the next sample 1 -> output (5-3+7+1)>>>3 = 1.
5. Back-pressure: hold write_ready=0 for 20 cycles after CAPTURE -> write=0, read=0 throughout, writedata held. Raise write_ready -> write pulses next cycle, exactly once.
6. Reset mid-flight: assert resetn=0 in WAIT_WR -> write never fires, writedata_*=0 immediately. After release, feed 800 -> output 100 (history cleared).
